ps2_scancode_filter: RTL and testbench

- Sits between the PS/2 byte receiver and password_checker.
- Takes raw scan-code bytes from the receiver and strips break sequences (F0 xx), extended prefixes (E0) and keyboard status bytes.
- Queues the remaining make codes in a first-word-fall-through FIFO.
- Presents code/empty to password_checker, which pops entries with rd_en.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/sync_fifo_fwft.sv | 71 +++++++
 rtl/ps2_scancode_filter.sv | 132 +++++++++++++
 tb/tb_ps2_scancode_filter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 scan-code constants and filter state type
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {IDLE, EXT, BRK} ps2_filt_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with registered flags
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;
    logic [CNT_W-1:0] count_nxt;

    // A pop on a full FIFO frees the slot the same-cycle push lands in;
    // a pop on an empty FIFO is ignored even if a push arrives with it.
    always_comb begin
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointer, occupancy and flag registers; flags come from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == DEPTH_C);
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_scancode_filter.sv
// rtl/ps2_scancode_filter.sv - strips break/extended/status bytes, queues make codes (option: PS2_FILTER_TYPEMATIC_EN)
module ps2_scancode_filter
    import ps2_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CODE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [CODE_W-1:0] rx_data,
    input  logic              rd_en,
    output logic [CODE_W-1:0] code,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CODE_W-1:0] C_BREAK = CODE_W'(PS2_BREAK);
    localparam logic [CODE_W-1:0] C_EXT   = CODE_W'(PS2_EXT);

    ps2_filt_state_t  state;
    ps2_filt_state_t  state_nxt;
    logic             make;
    logic             push_req;
    logic             status_byte;
    logic [CNT_W-1:0] fifo_count;

    // Keyboard status/error bytes that never represent a key press.
    always_comb begin
        status_byte = (rx_data == CODE_W'(PS2_BAT_OK)) || (rx_data == CODE_W'(PS2_ACK))  ||
                      (rx_data == CODE_W'(PS2_RESEND)) || (rx_data == CODE_W'(PS2_ERR0)) ||
                      (rx_data == CODE_W'(PS2_ERR1));
    end

    // Prefix tracking: decide next state and whether this byte is a make code.
    always_comb begin
        state_nxt = state;
        make      = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == C_EXT) begin
                        state_nxt = EXT;
                    end else if (rx_data == C_BREAK) begin
                        state_nxt = BRK;
                    end else if (!status_byte) begin
                        make = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == C_BREAK) begin
                        state_nxt = BRK;
                    end else if (rx_data != C_EXT) begin
                        make      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Prefix state register; reset drops any partially received sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef PS2_FILTER_TYPEMATIC_EN
    logic [CODE_W-1:0] held_code;
    logic              held_valid;

    // A held key auto-repeats its make code; only the first one is queued.
    always_comb begin
        push_req = make && !(held_valid && (rx_data == held_code));
    end

    // Remember the key currently held down until its break code is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_code  <= '0;
            held_valid <= 1'b0;
        end else if (make) begin
            held_code  <= rx_data;
            held_valid <= 1'b1;
        end else if (rx_valid && (state == BRK) && (rx_data == held_code)) begin
            held_valid <= 1'b0;
        end
    end
`else
    // Every make code is queued, repeats included.
    always_comb begin
        push_req = make;
    end
`endif

    // Sticky flag: a make code was lost because no slot was free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_req && (fifo_count == DEPTH_C) && !rd_en) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (rx_data),
        .pop       (rd_en),
        .pop_data  (code),
        .empty     (empty),
        .full      (full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ps2_scancode_filter.sv
// tb/tb_ps2_scancode_filter.sv - scoreboard bench for ps2_scancode_filter
module tb_ps2_scancode_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] code;
    logic       empty;
    logic       full;
    logic       overflow;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] sb_q[$];

    ps2_scancode_filter #(.DEPTH(8), .CODE_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rd_en    (rd_en),
        .code     (code),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Tasks are entered and left at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] exp;
        exp = sb_q.pop_front();
        tests_run++;
        if (empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s pop_empty: empty=%b required 0", tag, empty);
        end
        tests_run++;
        if (code !== exp) begin
            tests_failed++;
            $display("FAIL %s pop_code: code=%h required %h", tag, code, exp);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb_q.size() > 0) pop_one(tag);
        tests_run++;
        if (empty !== 1'b1 || code !== 8'h00) begin
            tests_failed++;
            $display("FAIL %s drained: empty=%b code=%h required 1 00", tag, empty, code);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || code !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset: empty=%b full=%b ovf=%b code=%h required 1 0 0 00",
                     empty, full, overflow, code);
        end
    endtask

    task automatic test_break_strip();
        do_reset();
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL brk_pre_push_empty: empty=%b required 1", empty);
        end
        sb_q.push_back(8'h2C);
        send(8'h2C);
        tests_run++;
        if (empty !== 1'b0 || code !== 8'h2C) begin
            tests_failed++;
            $display("FAIL brk_first_push: empty=%b code=%h required 0 2c", empty, code);
        end
        send(8'hF0); send(8'h2C);
        sb_q.push_back(8'h24);
        send(8'h24);
        send(8'hF0); send(8'h24);
        drain("brk");
    endtask

    task automatic test_status_ext();
        do_reset();
        send(8'hAA); send(8'hFA);
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL status_discard: empty=%b required 1", empty);
        end
        send(8'hE0);
        sb_q.push_back(8'h75);
        send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        // A plain byte afterwards must be queued, proving the FSM returned to IDLE.
        sb_q.push_back(8'h3C);
        send(8'h3C);
        drain("ext");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(8'h10 + 8'(i));
            send(8'h10 + 8'(i));
        end
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_full8: full=%b ovf=%b required 1 0", full, overflow);
        end
        send(8'h18);
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_ninth: full=%b ovf=%b required 1 1", full, overflow);
        end
        drain("ovf");
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: ovf=%b required 1", overflow);
        end
        do_reset();
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_reset_clear: ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(8'h20 + 8'(i));
            send(8'h20 + 8'(i));
        end
        exp = sb_q.pop_front();
        tests_run++;
        if (code !== exp) begin
            tests_failed++;
            $display("FAIL fpp_head: code=%h required %h", code, exp);
        end
        sb_q.push_back(8'h1B);
        rx_valid = 1'b1;
        rx_data = 8'h1B;
        rd_en = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rd_en = 1'b0;
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL fpp_flags: full=%b ovf=%b required 1 0", full, overflow);
        end
        drain("fpp");
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        sb_q.push_back(8'h4D);
        rx_valid = 1'b1;
        rx_data = 8'h4D;
        rd_en = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rd_en = 1'b0;
        tests_run++;
        if (empty !== 1'b0 || code !== 8'h4D) begin
            tests_failed++;
            $display("FAIL epp_push_kept: empty=%b code=%h required 0 4d", empty, code);
        end
        drain("epp");
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        tests_run++;
        if (empty !== 1'b1 || code !== 8'h00 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL epp_underflow: empty=%b code=%h ovf=%b required 1 00 0", empty, code, overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h30); send(8'h31); send(8'h32); send(8'hF0);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || code !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstmid_async: empty=%b full=%b ovf=%b code=%h required 1 0 0 00",
                     empty, full, overflow, code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        sb_q.push_back(8'h3C);
        send(8'h3C);
        drain("rstmid");
    endtask

    task automatic test_typematic();
        do_reset();
        sb_q.push_back(8'h2C);
`ifdef PS2_FILTER_TYPEMATIC_EN
        sb_q.push_back(8'h2C);
`else
        sb_q.push_back(8'h2C);
        sb_q.push_back(8'h2C);
        sb_q.push_back(8'h2C);
`endif
        send(8'h2C); send(8'h2C); send(8'h2C);
        send(8'hF0); send(8'h2C);
        send(8'h2C);
        drain("typematic");
    endtask

    initial begin
        test_reset();
        test_break_strip();
        test_status_ext();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_reset_mid();
        test_typematic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
